// File: rtl/pipeline_execute_mc.sv
// Execute stage with operand forwarding, load-use hazard detection,
// a single-cycle ALU path and a multi-cycle shift-add multiplier.
// Results sit in one output register under a valid/ready handshake.
module pipeline_execute_mc #(
    parameter int          DATA_W     = 16,
    parameter logic [3:0]  MUL_OPCODE = 4'b1001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    output logic [2:0]        rn_num,
    output logic [2:0]        rm_num,
    input  logic [DATA_W-1:0] rn_data,
    input  logic [DATA_W-1:0] rm_data,
    input  logic              mem_valid,
    input  logic              mem_writes_reg,
    input  logic              mem_done,
    input  logic [2:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_instr,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        out_rd,
    output logic              out_writes_reg,
    output logic              out_done,
    output logic              out_z,
    output logic              out_n,
    output logic              busy
);

    // Instruction classes on instr[15:14]; 4'b1000 is a load (result arrives later).
    localparam logic [1:0] A_TYPE  = 2'b00;
    localparam logic [1:0] R_TYPE  = 2'b01;
    localparam logic [3:0] LOAD_OP = 4'b1000;
    localparam int         CNT_W   = $clog2(DATA_W + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  acc_q, mcand_q, mplier_q;
    logic [15:0]        mul_instr_q;

    logic               out_valid_q, out_writes_reg_q, out_done_q, out_z_q, out_n_q;
    logic [15:0]        out_instr_q;
    logic [DATA_W-1:0]  out_result_q;
    logic [2:0]         out_rd_q;

    logic               writes_reg, done, is_mul, hazard, accept, out_free;
    logic               own_fwd_ok, mem_fwd_ok, load_alu, load_mul;
    logic [DATA_W-1:0]  rn_val, rm_val, alu_res, mul_sum;

    function automatic logic writes_reg_f(input logic [15:0] ins);
        return (ins[15:14] == A_TYPE) || (ins[15:14] == R_TYPE) ||
               (ins[15:12] == LOAD_OP) || (ins[15:12] == MUL_OPCODE);
    endfunction

    function automatic logic [DATA_W-1:0] alu_f(input logic [15:0] ins,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        case (ins[15:12])
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return b;
            4'b0110: return a << 1;
            4'b0111: return a >> 1;
            default: return a + b;   // loads and non-writing ops: address sum
        endcase
    endfunction

    assign rn_num     = instr[5:3];
    assign rm_num     = instr[8:6];
    assign writes_reg = writes_reg_f(instr);
    assign done       = writes_reg && (instr[15:12] != LOAD_OP);
    assign is_mul     = (instr[15:12] == MUL_OPCODE);

    // While multiplying, the output register holds an older instruction, so never forward from it.
    assign own_fwd_ok = (state_q == S_IDLE) && out_valid_q && out_writes_reg_q && out_done_q;
    assign mem_fwd_ok = mem_valid && mem_writes_reg && mem_done;

    // Forwarding mux: own output beats memory stage beats regfile.
    always_comb begin
        rn_val = rn_data;
        rm_val = rm_data;
        if (own_fwd_ok && out_rd_q == rn_num)      rn_val = out_result_q;
        else if (mem_fwd_ok && mem_rd == rn_num)   rn_val = mem_result;
        if (own_fwd_ok && out_rd_q == rm_num)      rm_val = out_result_q;
        else if (mem_fwd_ok && mem_rd == rm_num)   rm_val = mem_result;
    end

    assign hazard = (out_valid_q && out_writes_reg_q && !out_done_q &&
                     (out_rd_q == rn_num || out_rd_q == rm_num)) ||
                    (mem_valid && mem_writes_reg && !mem_done &&
                     (mem_rd == rn_num || mem_rd == rm_num));

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == S_IDLE) && !hazard && out_free;
    assign accept   = in_valid && in_ready;
    assign alu_res  = alu_f(instr, rn_val, rm_val);
    // Once all multiplier bits are consumed mplier_q is zero, so this equals acc_q.
    assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state and load decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_alu = 1'b0;
        load_mul = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q >= CNT_W'(DATA_W - 1) && out_free) begin
                    load_mul = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multiplier datapath: capture on accept, then one shift-add step per cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && accept && is_mul) begin
            acc_q       <= '0;
            mcand_q     <= rn_val;
            mplier_q    <= rm_val;
            mul_instr_q <= instr;
        end else if (state_q == S_MUL && cnt_q != CNT_W'(DATA_W)) begin
            acc_q    <= mul_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    // Output register: load ALU or multiply result, else drop valid once consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q      <= 1'b0;
            out_instr_q      <= '0;
            out_result_q     <= '0;
            out_rd_q         <= '0;
            out_writes_reg_q <= 1'b0;
            out_done_q       <= 1'b0;
            out_z_q          <= 1'b0;
            out_n_q          <= 1'b0;
        end else if (load_alu) begin
            out_valid_q      <= 1'b1;
            out_instr_q      <= instr;
            out_result_q     <= alu_res;
            out_rd_q         <= instr[2:0];
            out_writes_reg_q <= writes_reg;
            out_done_q       <= done;
            out_z_q          <= (alu_res == '0);
            out_n_q          <= alu_res[DATA_W-1];
        end else if (load_mul) begin
            out_valid_q      <= 1'b1;
            out_instr_q      <= mul_instr_q;
            out_result_q     <= mul_sum;
            out_rd_q         <= mul_instr_q[2:0];
            out_writes_reg_q <= 1'b1;
            out_done_q       <= 1'b1;
            out_z_q          <= (mul_sum == '0);
            out_n_q          <= mul_sum[DATA_W-1];
        end else if (out_ready) begin
            out_valid_q      <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_instr      = out_instr_q;
    assign out_result     = out_result_q;
    assign out_rd         = out_rd_q;
    assign out_writes_reg = out_writes_reg_q;
    assign out_done       = out_done_q;
    assign out_z          = out_z_q;
    assign out_n          = out_n_q;
    assign busy           = (state_q == S_MUL);

endmodule

// File: tb/tb_pipeline_execute_mc.sv
// Directed bench for pipeline_execute_mc: ALU path, forwarding, hazards,
// multi-cycle multiply, backpressure and asynchronous reset.
module tb_pipeline_execute_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [15:0] instr;
    logic [2:0]  rn_num, rm_num;
    logic [15:0] rn_data, rm_data;
    logic        mem_valid, mem_writes_reg, mem_done;
    logic [2:0]  mem_rd;
    logic [15:0] mem_result;
    logic        out_valid, out_ready;
    logic [15:0] out_instr, out_result;
    logic [2:0]  out_rd;
    logic        out_writes_reg, out_done, out_z, out_n, busy;

    logic [15:0] rf [8];
    int n_checks = 0;
    int n_err    = 0;

    pipeline_execute_mc #(.DATA_W(16), .MUL_OPCODE(4'b1001)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rn_num(rn_num), .rm_num(rm_num), .rn_data(rn_data), .rm_data(rm_data),
        .mem_valid(mem_valid), .mem_writes_reg(mem_writes_reg), .mem_done(mem_done),
        .mem_rd(mem_rd), .mem_result(mem_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_result(out_result), .out_rd(out_rd),
        .out_writes_reg(out_writes_reg), .out_done(out_done),
        .out_z(out_z), .out_n(out_n), .busy(busy)
    );

    always #5 clk = ~clk;

    assign rn_data = rf[rn_num];
    assign rm_data = rf[rm_num];

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rm,
                                       input logic [2:0] rn, input logic [2:0] rd);
        return {op, 3'b000, rm, rn, rd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int seen;
        for (int i = 0; i < 8; i++) rf[i] = '0;
        rf[2] = 16'd5;
        rf[3] = 16'd7;
        reset_n = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        mem_valid = 1'b0; mem_writes_reg = 1'b0; mem_done = 1'b0;
        mem_rd = '0; mem_result = '0;
        #2 reset_n = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_result", {16'd0, out_result}, 32'd0);
        chk("rst_out_instr", {16'd0, out_instr}, 32'd0);
        chk("rst_out_rd_done", {28'd0, out_rd, out_done}, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // ADD r1 = r2 + r3 on the first edge after release
        instr = mk(4'b0000, 3'd3, 3'd2, 3'd1); in_valid = 1'b1;
        #1;
        chk("rn_num", {29'd0, rn_num}, 32'd2);
        chk("rm_num", {29'd0, rm_num}, 32'd3);
        chk("add_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_result", {16'd0, out_result}, 32'd12);
        chk("add_rd", {29'd0, out_rd}, 32'd1);
        chk("add_done_wr", {30'd0, out_done, out_writes_reg}, 32'd3);

        // SUB r4 = r1 - r2 back-to-back, r1 forwarded from own output
        instr = mk(4'b0001, 3'd2, 3'd1, 3'd4);
        #1;
        chk("sub_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sub_valid", {31'd0, out_valid}, 32'd1);
        chk("sub_fwd_result", {16'd0, out_result}, 32'd7);
        chk("sub_rd", {29'd0, out_rd}, 32'd4);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_hold", {16'd0, out_result}, 32'd7);

        // Flag cases: zero then negative
        instr = mk(4'b0001, 3'd2, 3'd2, 3'd6); in_valid = 1'b1;
        tick();
        chk("zero_result", {16'd0, out_result}, 32'd0);
        chk("zero_zn", {30'd0, out_z, out_n}, 32'd2);
        instr = mk(4'b0001, 3'd3, 3'd2, 3'd6);
        tick();
        chk("neg_result", {16'd0, out_result}, 32'h0000FFFE);
        chk("neg_zn", {30'd0, out_z, out_n}, 32'd1);
        in_valid = 1'b0;
        tick();

        // MUL r5 = r2 * r3 with 300 * 300
        rf[2] = 16'd300; rf[3] = 16'd300;
        instr = mk(4'b1001, 3'd3, 3'd2, 3'd5); in_valid = 1'b1;
        tick();
        chk("mul_busy", {31'd0, busy}, 32'd1);
        instr = mk(4'b0000, 3'd3, 3'd2, 3'd1);
        #1;
        chk("mul_in_ready", {31'd0, in_ready}, 32'd0);
        lat = 0; busy_cnt = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        in_valid = 1'b0;
        chk("mul_latency", lat, 32'd16);
        chk("mul_busy_cycles", busy_cnt, 32'd16);
        chk("mul_result", {16'd0, out_result}, 32'h00005F90);
        chk("mul_rd", {29'd0, out_rd}, 32'd5);
        chk("mul_zn", {30'd0, out_z, out_n}, 32'd0);
        chk("mul_busy_end", {31'd0, busy}, 32'd0);

        // Load to r2, then a reader of r2 stalls until memory delivers
        instr = mk(4'b1000, 3'd0, 3'd0, 3'd2); in_valid = 1'b1;
        tick();
        chk("ld_valid", {31'd0, out_valid}, 32'd1);
        chk("ld_done_wr", {30'd0, out_done, out_writes_reg}, 32'd1);
        instr = mk(4'b0000, 3'd3, 3'd2, 3'd1);
        #1;
        chk("ld_haz_out", {31'd0, in_ready}, 32'd0);
        tick();
        chk("ld_consumed", {31'd0, out_valid}, 32'd0);
        mem_valid = 1'b1; mem_writes_reg = 1'b1; mem_done = 1'b0; mem_rd = 3'd2;
        #1;
        chk("ld_haz_mem", {31'd0, in_ready}, 32'd0);
        tick();
        chk("ld_stall_valid", {31'd0, out_valid}, 32'd0);
        mem_done = 1'b1; mem_result = 16'd100;
        #1;
        chk("ld_released", {31'd0, in_ready}, 32'd1);
        tick();
        chk("ld_fwd_valid", {31'd0, out_valid}, 32'd1);
        chk("ld_fwd_result", {16'd0, out_result}, 32'd400);
        mem_valid = 1'b0; mem_done = 1'b0; mem_writes_reg = 1'b0;

        // Backpressure: hold the result for 5 cycles
        out_ready = 1'b0;
        instr = mk(4'b0001, 3'd2, 3'd3, 3'd4);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", {16'd0, out_result}, 32'd400);
            chk("bp_rd", {29'd0, out_rd}, 32'd1);
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_hold", {16'd0, out_result}, 32'd400);

        // Reset during the 8th cycle of a multiply
        instr = mk(4'b1001, 3'd3, 3'd2, 3'd5); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        chk("rmul_busy", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rmul_busy_clr", {31'd0, busy}, 32'd0);
        chk("rmul_valid_clr", {31'd0, out_valid}, 32'd0);
        chk("rmul_result_clr", {16'd0, out_result}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("rmul_no_result", seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
